// File: rtl/counter_sched_if.sv
// counter_sched_if: host-side run-control bundle for counter_sched.
// Master drives the run controls and settings; slave (the scheduler)
// returns count, tick/done events and run status.
// Optional: COUNTER_SCHED_WRAP_CNT_EN adds the wrap_cnt status bus.
interface counter_sched_if #(
    parameter int CNT_WIDTH = 3,
    parameter int PRE_WIDTH = 4
);
    logic                 start;
    logic                 stop;
    logic                 pause;
    logic                 periodic;
    logic [CNT_WIDTH-1:0] term_val;
    logic [PRE_WIDTH-1:0] prescale;
    logic [CNT_WIDTH-1:0] count;
    logic                 tick;
    logic                 done;
    logic                 busy;
    logic [1:0]           state;
`ifdef COUNTER_SCHED_WRAP_CNT_EN
    logic [7:0]           wrap_cnt;

    modport master (
        output start, stop, pause, periodic, term_val, prescale,
        input  count, tick, done, busy, state, wrap_cnt
    );

    modport slave (
        input  start, stop, pause, periodic, term_val, prescale,
        output count, tick, done, busy, state, wrap_cnt
    );
`else
    modport master (
        output start, stop, pause, periodic, term_val, prescale,
        input  count, tick, done, busy, state
    );

    modport slave (
        input  start, stop, pause, periodic, term_val, prescale,
        output count, tick, done, busy, state
    );
`endif
endinterface

// File: rtl/counter_sched.sv
// counter_sched: run-control scheduler for an up-counter with prescaled
// tick, programmable terminal count and one-shot/periodic modes.
// Controls: stop > start > pause. Settings are latched on start only.
// Optional: COUNTER_SCHED_WRAP_CNT_EN adds a saturating count of
// periodic terminal events (wrap_cnt).
module counter_sched #(
    parameter int CNT_WIDTH = 3,
    parameter int PRE_WIDTH = 4
) (
    input logic              clk,
    input logic              reset,
    counter_sched_if.slave   bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]           state_r;
    logic [CNT_WIDTH-1:0] count_r;
    logic [PRE_WIDTH-1:0] pre_cnt;
    logic                 tick_r;
    logic                 done_r;

    logic [CNT_WIDTH-1:0] term_l;
    logic [PRE_WIDTH-1:0] prescale_l;
    logic                 periodic_l;

    // A prescaler wrap in RUN with no overriding control is a tick event.
    logic                 run_step;
    logic                 tick_evt;
    logic                 term_hit;

    assign run_step = (state_r == RUN) && !bus.stop && !bus.start && !bus.pause;
    assign tick_evt = run_step && (pre_cnt == prescale_l);
    assign term_hit = tick_evt && (count_r == term_l);

    // Run settings are captured only when a run is (re)started.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            term_l     <= '0;
            prescale_l <= '0;
            periodic_l <= 1'b0;
        end else if (!bus.stop && bus.start) begin
            term_l     <= bus.term_val;
            prescale_l <= bus.prescale;
            periodic_l <= bus.periodic;
        end
    end

    // Run-state FSM with count, prescaler and the single-cycle event pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            count_r <= '0;
            pre_cnt <= '0;
            tick_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            tick_r <= tick_evt;
            done_r <= term_hit;
            if (bus.stop) begin
                state_r <= IDLE;
                count_r <= '0;
                pre_cnt <= '0;
            end else if (bus.start) begin
                state_r <= RUN;
                count_r <= '0;
                pre_cnt <= '0;
            end else begin
                case (state_r)
                    RUN: begin
                        if (bus.pause) begin
                            state_r <= PAUSE;
                        end else if (pre_cnt == prescale_l) begin
                            pre_cnt <= '0;
                            if (count_r == term_l) begin
                                // Periodic reloads; one-shot parks at term_l.
                                if (periodic_l) begin
                                    count_r <= '0;
                                end else begin
                                    state_r <= DONE;
                                end
                            end else begin
                                count_r <= count_r + CNT_WIDTH'(1);
                            end
                        end else begin
                            pre_cnt <= pre_cnt + PRE_WIDTH'(1);
                        end
                    end
                    PAUSE: begin
                        // Prescaler phase is kept, so resuming loses no time.
                        if (!bus.pause) begin
                            state_r <= RUN;
                        end
                    end
                    default: begin
                        // IDLE and DONE hold until start or stop.
                    end
                endcase
            end
        end
    end

`ifdef COUNTER_SCHED_WRAP_CNT_EN
    logic [7:0] wrap_r;

    // Saturating count of periodic terminal events since the last start/stop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_r <= 8'd0;
        end else if (bus.stop || bus.start) begin
            wrap_r <= 8'd0;
        end else if (term_hit && periodic_l && (wrap_r != 8'hFF)) begin
            wrap_r <= wrap_r + 8'd1;
        end
    end

    assign bus.wrap_cnt = wrap_r;
`endif

    assign bus.state = state_r;
    assign bus.count = count_r;
    assign bus.tick  = tick_r;
    assign bus.done  = done_r;
    assign bus.busy  = (state_r == RUN) || (state_r == PAUSE);

endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: directed scenarios plus randomized control traffic for
// counter_sched, checked every cycle against a run-edge-count model.
module tb_counter_sched;
    localparam int CW = 3;
    localparam int PW = 4;

    logic clk;
    logic reset;

    counter_sched_if #(.CNT_WIDTH(CW), .PRE_WIDTH(PW)) bus ();

    counter_sched #(.CNT_WIDTH(CW), .PRE_WIDTH(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: the run is described by the number of counting RUN edges since
    // start; count, tick and done follow from integer division of that number.
    int m_st, m_n, m_T, m_P, m_per, m_tick, m_done, m_wrap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_n = 0; m_T = 0; m_P = 0; m_per = 0;
        m_tick = 0; m_done = 0; m_wrap = 0;
    endtask

    function automatic int exp_count();
        int ticks;
        ticks = m_n / (m_P + 1);
        if (m_st == 0) return 0;
        if (m_st == 3) return m_T;
        if (m_per != 0) return ticks % (m_T + 1);
        return ticks;
    endfunction

    task automatic model_step();
        m_tick = 0;
        m_done = 0;
        if (bus.stop) begin
            m_st = 0; m_n = 0; m_wrap = 0;
        end else if (bus.start) begin
            m_T = int'(bus.term_val); m_P = int'(bus.prescale); m_per = int'(bus.periodic);
            m_st = 1; m_n = 0; m_wrap = 0;
        end else if (m_st == 1) begin
            if (bus.pause) begin
                m_st = 2;
            end else begin
                m_n++;
                if (m_n % (m_P + 1) == 0) begin
                    m_tick = 1;
                    if ((m_n / (m_P + 1)) % (m_T + 1) == 0) begin
                        m_done = 1;
                        if (m_per != 0) begin
                            if (m_wrap < 255) m_wrap++;
                        end else begin
                            m_st = 3;
                        end
                    end
                end
            end
        end else if (m_st == 2 && !bus.pause) begin
            m_st = 1;
        end
    endtask

    task automatic check_all();
        chk("count", 32'(bus.count), exp_count());
        chk("tick",  32'(bus.tick),  m_tick);
        chk("done",  32'(bus.done),  m_done);
        chk("state", 32'(bus.state), m_st);
        chk("busy",  32'(bus.busy),  (m_st == 1 || m_st == 2) ? 1 : 0);
`ifdef COUNTER_SCHED_WRAP_CNT_EN
        chk("wrap_cnt", 32'(bus.wrap_cnt), m_wrap);
`endif
    endtask

    // Inputs are set between edges; the model consumes the same values the DUT samples.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_ctl(input logic s, input logic p, input logic pa);
        bus.start = s; bus.stop = p; bus.pause = pa;
    endtask

    task automatic go(input int term, input int pre, input logic per);
        bus.term_val = CW'(term); bus.prescale = PW'(pre); bus.periodic = per;
        set_ctl(1'b1, 1'b0, 1'b0);
        step();
        set_ctl(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int guard;
        reset = 1'b1;
        set_ctl(1'b0, 1'b0, 1'b0);
        bus.periodic = 1'b0; bus.term_val = '0; bus.prescale = '0;
        model_reset();
        #12;
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_busy",  32'(bus.busy),  0);
        chk("rst_tick",  32'(bus.tick),  0);
        chk("rst_done",  32'(bus.done),  0);
        reset = 1'b0;
        step();

        // Periodic term=3, prescale=0: 1,2,3,0 with done at edge 4.
        go(3, 0, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("p3_count", 32'(bus.count), i % 4);
            chk("p3_done",  32'(bus.done),  (i % 4 == 0) ? 1 : 0);
            chk("p3_tick",  32'(bus.tick),  1);
        end
        bus.stop = 1'b1; step(); bus.stop = 1'b0;

        // One-shot term=5, prescale=2: done exactly at edge 18.
        go(5, 2, 1'b0);
        for (int i = 1; i <= 17; i++) step();
        step();
        chk("os_done18",  32'(bus.done),  1);
        chk("os_count18", 32'(bus.count), 5);
        chk("os_state18", 32'(bus.state), 3);
        chk("os_busy18",  32'(bus.busy),  0);
        bus.pause = 1'b1;
        for (int i = 0; i < 4; i++) step();
        bus.pause = 1'b0;
        chk("os_hold", 32'(bus.count), 5);

        // Periodic term=3, prescale=1 with a 6-cycle pause at count=2.
        go(3, 1, 1'b1);
        guard = 0;
        while (bus.count != CW'(2) && guard < 20) begin step(); guard++; end
        chk("pz_reach2", (guard < 20) ? 1 : 0, 1);
        bus.pause = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("pz_frozen", 32'(bus.count), 2);
        end
        chk("pz_state", 32'(bus.state), 2);
        bus.pause = 1'b0;
        for (int i = 0; i < 8; i++) step();

        // Stop coinciding with the terminal tick.
        go(3, 0, 1'b1);
        for (int i = 0; i < 3; i++) step();
        bus.stop = 1'b1; step(); bus.stop = 1'b0;
        chk("stop_done",  32'(bus.done),  0);
        chk("stop_state", 32'(bus.state), 0);
        chk("stop_count", 32'(bus.count), 0);

        // Restart from RUN at count=2 with term=1.
        go(5, 0, 1'b1);
        step(); step();
        chk("rs_pre", 32'(bus.count), 2);
        go(1, 0, 1'b1);
        chk("rs_cnt0", 32'(bus.count), 0);
        chk("rs_nodone", 32'(bus.done), 0);
        step(); chk("rs_cnt1", 32'(bus.count), 1);
        step(); chk("rs_done", 32'(bus.done), 1);
        chk("rs_cnt_wrap", 32'(bus.count), 0);

        // term=0 periodic: done and tick every cycle; long run for saturation.
        go(0, 0, 1'b1);
        for (int i = 0; i < 260; i++) step();
        chk("t0_count", 32'(bus.count), 0);
        chk("t0_done",  32'(bus.done),  1);
`ifdef COUNTER_SCHED_WRAP_CNT_EN
        chk("t0_wrap_sat", 32'(bus.wrap_cnt), 255);
`endif

        // term=7 one-shot: all-ones count is reached before done.
        go(7, 0, 1'b0);
        for (int i = 0; i < 7; i++) step();
        chk("t7_count", 32'(bus.count), 7);
        chk("t7_nodone", 32'(bus.done), 0);
        step();
        chk("t7_done", 32'(bus.done), 1);

        // Asynchronous reset mid-run, applied away from the clock edge.
        go(4, 1, 1'b1);
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        #2;
        model_reset();
        chk("arst_state", 32'(bus.state), 0);
        chk("arst_count", 32'(bus.count), 0);
        chk("arst_done",  32'(bus.done),  0);
        reset = 1'b0;
        step();

        // Randomized control traffic, settings changing mid-run.
        for (int i = 0; i < 600; i++) begin
            bus.start    = ($urandom_range(0, 19) == 0);
            bus.stop     = ($urandom_range(0, 39) == 0);
            bus.pause    = ($urandom_range(0, 6) == 0);
            bus.periodic = 1'($urandom_range(0, 1));
            bus.term_val = CW'($urandom_range(0, 7));
            bus.prescale = PW'($urandom_range(0, 3));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
